// File: rtl/bcd_display_ctrl.sv
// Signed product to sign + 5 BCD digits via shift-and-add-3,
// driving a scrollable 4-digit multiplexed display window.
module bcd_display_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prod_valid,
  input  logic [15:0] prod,
  output logic        busy,
  output logic        bcd_valid,
  output logic [19:0] digits,
  output logic        neg,
  input  logic        scroll_left,
  input  logic        scroll_right,
  output logic [1:0]  window,
  output logic [3:0]  an,
  output logic [3:0]  cur_digit
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] RMAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CONV,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [14:0] magin_q, magin_d;
  logic [19:0] scr_q, scr_d;
  logic [14:0] mag_q, mag_d;
  logic [3:0]  bit_q, bit_d;
  logic [19:0] digits_q, digits_d;
  logic        neg_q, neg_d;
  logic [1:0]  win_q, win_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [1:0]  idx_q, idx_d;

  logic [14:0] prod_abs;
  logic [14:0] prod_twos;
  logic [19:0] scr_adj;
  logic [34:0] shifted;

  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[4*i +: 4] > 4'd4)
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Low 15 bits negated give |prod| except for -32768, saturated here
  always_comb begin
    prod_twos = 15'(~prod[14:0]) + 15'd1;
    prod_abs  = prod[14:0];
    if (prod[15]) begin
      if (prod[14:0] == 15'd0)
        prod_abs = 15'h7fff;
      else
        prod_abs = prod_twos;
    end
  end

  assign scr_adj = add3(scr_q);
  assign shifted = {scr_adj, mag_q} << 1;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    magin_d  = magin_q;
    scr_d    = scr_q;
    mag_d    = mag_q;
    bit_d    = bit_q;
    digits_d = digits_q;
    neg_d    = neg_q;
    unique case (state_q)
      IDLE: begin
        if (prod_valid) begin
          sign_d  = prod[15];
          magin_d = prod_abs;
          state_d = LOAD;
        end
      end
      LOAD: begin
        scr_d   = 20'd0;
        mag_d   = magin_q;
        bit_d   = 4'd14;
        state_d = CONV;
      end
      CONV: begin
        scr_d = shifted[34:15];
        mag_d = shifted[14:0];
        bit_d = bit_q - 4'd1;
        // Publish on the final shift so DONE already shows the result
        if (bit_q == 4'd0) begin
          digits_d = shifted[34:15];
          neg_d    = sign_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    win_d = win_q;
    if (scroll_left && !scroll_right && win_q != 2'd2)
      win_d = win_q + 2'd1;
    else if (scroll_right && !scroll_left && win_q != 2'd0)
      win_d = win_q - 2'd1;
  end

  always_comb begin
    rcnt_d = rcnt_q + CW'(1);
    idx_d  = idx_q;
    if (rcnt_q == RMAX) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      magin_q  <= 15'd0;
      scr_q    <= 20'd0;
      mag_q    <= 15'd0;
      bit_q    <= 4'd0;
      digits_q <= 20'd0;
      neg_q    <= 1'b0;
      win_q    <= 2'd0;
      rcnt_q   <= '0;
      idx_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      magin_q  <= magin_d;
      scr_q    <= scr_d;
      mag_q    <= mag_d;
      bit_q    <= bit_d;
      digits_q <= digits_d;
      neg_q    <= neg_d;
      win_q    <= win_d;
      rcnt_q   <= rcnt_d;
      idx_q    <= idx_d;
    end
  end

  logic [3:0] d4, d3, d2, d1, d0;
  logic       lz4, lz3, lz2, lz1;
  logic [2:0] pos;

  assign d4 = digits_q[19:16];
  assign d3 = digits_q[15:12];
  assign d2 = digits_q[11:8];
  assign d1 = digits_q[7:4];
  assign d0 = digits_q[3:0];

  // lzN: digit N and every higher digit are zero
  assign lz4 = (d4 == 4'd0);
  assign lz3 = lz4 && (d3 == 4'd0);
  assign lz2 = lz3 && (d2 == 4'd0);
  assign lz1 = lz2 && (d1 == 4'd0);

  assign pos = {1'b0, win_q} + {1'b0, idx_q};

  always_comb begin
    cur_digit = 4'hF;
    case (pos)
      3'd5: cur_digit = neg_q ? 4'hA : 4'hF;
      3'd4: cur_digit = lz4 ? 4'hF : d4;
      3'd3: cur_digit = lz3 ? 4'hF : d3;
      3'd2: cur_digit = lz2 ? 4'hF : d2;
      3'd1: cur_digit = lz1 ? 4'hF : d1;
      3'd0: cur_digit = d0;
      default: cur_digit = 4'hF;
    endcase
  end

  assign an        = ~(4'b0001 << idx_q);
  assign busy      = (state_q != IDLE);
  assign bcd_valid = (state_q == DONE);
  assign digits    = digits_q;
  assign neg       = neg_q;
  assign window    = win_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: decimal-arithmetic reference model,
// directed plan scenarios plus randomized products and scrolls.
module tb_bcd_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prod_valid;
  logic [15:0] prod;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] digits;
  logic        neg;
  logic        scroll_left;
  logic        scroll_right;
  logic [1:0]  window;
  logic [3:0]  an;
  logic [3:0]  cur_digit;

  int tests_run = 0;
  int failed = 0;

  int m_cyc;
  int m_val;
  bit m_neg;
  int m_win;

  bcd_display_ctrl #(.REFRESH_DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .prod_valid(prod_valid),
    .prod(prod),
    .busy(busy),
    .bcd_valid(bcd_valid),
    .digits(digits),
    .neg(neg),
    .scroll_left(scroll_left),
    .scroll_right(scroll_right),
    .window(window),
    .an(an),
    .cur_digit(cur_digit)
  );

  always #5 clk = ~clk;

  // cycles elapsed since the last reset edge
  always @(posedge clk) begin
    if (!rst_n) m_cyc <= 0;
    else m_cyc <= m_cyc + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int div;
    r = '0;
    div = 1;
    for (int p = 0; p < 5; p++) begin
      r[4*p +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_code(input int p, input int v, input bit n);
    int div;
    if (p == 5) return n ? 4'hA : 4'hF;
    div = 1;
    for (int i = 0; i < p; i++) div = div * 10;
    if (p > 0 && v < div) return 4'hF;
    return 4'((v / div) % 10);
  endfunction

  task automatic check_disp(input string tag);
    int idx;
    logic [3:0] e_an, e_cd;
    for (int c = 0; c < 16; c++) begin
      idx = (m_cyc / 4) % 4;
      e_an = ~(4'b0001 << idx);
      e_cd = exp_code(m_win + idx, m_val, m_neg);
      tests_run++;
      if (an !== e_an) begin
        failed++;
        $display("FAIL %s an: got %b want %b", tag, an, e_an);
      end
      tests_run++;
      if (cur_digit !== e_cd) begin
        failed++;
        $display("FAIL %s cur_digit idx%0d: got %h want %h", tag, idx, cur_digit, e_cd);
      end
      tick;
    end
  endtask

  task automatic scroll(input bit l, input bit r);
    scroll_left = l;
    scroll_right = r;
    tick;
    scroll_left = 1'b0;
    scroll_right = 1'b0;
    if (l && !r && m_win < 2) m_win++;
    else if (r && !l && m_win > 0) m_win--;
    tests_run++;
    if (window !== 2'(m_win)) begin
      failed++;
      $display("FAIL scroll l%0b r%0b window: got %0d want %0d", l, r, window, m_win);
    end
  endtask

  // pulse p; optionally re-assert prod_valid with ip in cycle k+ia
  task automatic run_conv(input logic [15:0] p, input int ia, input logic [15:0] ip);
    int s, v;
    bit n;
    logic [19:0] old_d;
    bit old_n;
    s = int'($signed(p));
    n = (s < 0);
    v = n ? -s : s;
    if (v > 32767) v = 32767;
    old_d = to_bcd(m_val);
    old_n = m_neg;
    prod = p;
    prod_valid = 1'b1;
    tick;
    prod_valid = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i == ia) begin
        prod = ip;
        prod_valid = 1'b1;
      end
      tests_run++;
      if (busy !== 1'b1) begin
        failed++;
        $display("FAIL conv %h busy k+%0d: got %b want 1", p, i, busy);
      end
      tests_run++;
      if (bcd_valid !== (i == 17)) begin
        failed++;
        $display("FAIL conv %h bcd_valid k+%0d: got %b want %b", p, i, bcd_valid, i == 17);
      end
      if (i == 16) begin
        tests_run++;
        if (digits !== old_d || neg !== old_n) begin
          failed++;
          $display("FAIL conv %h hold: got %h/%b want %h/%b", p, digits, neg, old_d, old_n);
        end
      end
      if (i == 17) begin
        tests_run++;
        if (digits !== to_bcd(v)) begin
          failed++;
          $display("FAIL conv %h digits: got %h want %h", p, digits, to_bcd(v));
        end
        tests_run++;
        if (neg !== n) begin
          failed++;
          $display("FAIL conv %h neg: got %b want %b", p, neg, n);
        end
        tests_run++;
        if (window !== 2'(m_win)) begin
          failed++;
          $display("FAIL conv %h window: got %0d want %0d", p, window, m_win);
        end
      end
      tick;
      prod_valid = 1'b0;
    end
    m_val = v;
    m_neg = n;
    tests_run++;
    if (busy !== 1'b0 || bcd_valid !== 1'b0) begin
      failed++;
      $display("FAIL conv %h k+18: got busy %b valid %b want 0 0", p, busy, bcd_valid);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    tests_run++;
    if (busy !== 1'b0 || bcd_valid !== 1'b0 || digits !== 20'd0 ||
        neg !== 1'b0 || window !== 2'd0 || an !== 4'b1110) begin
      failed++;
      $display("FAIL %s: got b%b v%b d%h n%b w%0d an%b want 0 0 00000 0 0 1110",
               tag, busy, bcd_valid, digits, neg, window, an);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    m_val = 0;
    m_neg = 1'b0;
    m_win = 0;
    check_idle_reset("reset");
    check_disp("reset_disp");
  endtask

  task automatic test_convert;
    run_conv(16'd16384, 0, 16'd0);
    check_disp("16384_disp");
  endtask

  task automatic test_scroll;
    run_conv(16'hFB2E, 0, 16'd0);
    check_disp("m1234_w0");
    scroll(1'b1, 1'b0);
    scroll(1'b1, 1'b0);
    check_disp("m1234_w2");
    scroll(1'b1, 1'b0);
    scroll(1'b1, 1'b1);
    scroll(1'b0, 1'b1);
    scroll(1'b1, 1'b1);
    check_disp("m1234_w1");
  endtask

  task automatic test_back_to_back;
    run_conv(16'd99, 5, 16'd500);
    run_conv(16'd500, 0, 16'd0);
    check_disp("500_disp");
  endtask

  task automatic test_saturate;
    run_conv(16'h8000, 0, 16'd0);
    check_disp("m32768_disp");
    for (int i = 0; i < 3; i++) scroll(1'b0, 1'b1);
    run_conv(16'd0, 0, 16'd0);
    check_disp("zero_disp");
  endtask

  task automatic test_mid_reset;
    scroll(1'b1, 1'b0);
    prod = 16'd4321;
    prod_valid = 1'b1;
    tick;
    prod_valid = 1'b0;
    for (int i = 1; i < 8; i++) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    m_val = 0;
    m_neg = 1'b0;
    m_win = 0;
    check_idle_reset("mid_reset");
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
        failed++;
        $display("FAIL mid_reset quiet %0d: got v%b b%b want 0 0", i, bcd_valid, busy);
      end
      tick;
    end
    run_conv(16'd4321, 0, 16'd0);
    check_disp("4321_disp");
  endtask

  task automatic test_random;
    logic [15:0] p;
    int ops;
    for (int it = 0; it < 12; it++) begin
      p = 16'($urandom);
      if (it == 0) p = 16'hFFFF;
      run_conv(p, 0, 16'd0);
      ops = $urandom_range(0, 3);
      for (int j = 0; j < ops; j++)
        scroll(1'($urandom), 1'($urandom));
      check_disp("rand_disp");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    prod_valid = 1'b0;
    prod = 16'd0;
    scroll_left = 1'b0;
    scroll_right = 1'b0;
    test_reset;
    test_convert;
    test_scroll;
    test_back_to_back;
    test_saturate;
    test_mid_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
